banco_regs_param: RTL and testbench

//  Parametrised register file for the datapath: two combinational read ports, one write port
//  on the rising edge of clk, and a synchronous clear of all registers.

---
 rtl/banco_regs_pkg.sv | 14 +
 rtl/banco_regs_param_scoreboard.sv | 91 +++++++++
 rtl/banco_regs_param.sv | 128 ++++++++++++
 tb/tb_banco_regs_param.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/banco_regs_pkg.sv
// Shared definitions for the banco_regs_param register file.
//   BANCO_DATA_W / BANCO_ADDR_W : default register width and address width
//   DEPTH                       : number of registers at the default address width
//   reg_data_t / reg_addr_t     : data and address types at the default widths
package banco_regs_pkg;

    localparam int BANCO_DATA_W = 16;
    localparam int BANCO_ADDR_W = 4;
    localparam int DEPTH        = 2 ** BANCO_ADDR_W;

    typedef logic [BANCO_DATA_W-1:0] reg_data_t;
    typedef logic [BANCO_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/banco_regs_param_scoreboard.sv
// reg_scoreboard: one pending bit per register for RAW hazard detection.
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   wr_en, wr_addr       writeback; clears the pending bit of wr_addr
//   rsv_en, rsv_addr     issue reservation; sets the pending bit of rsv_addr
//   rd_addr_a/b          decode read addresses
//   pend_a/pend_b        raw pending bit at each read address
//   pend_cnt             number of pending bits currently set
// With ZERO_REG != 0, writes and reserves to register 0 are dropped, so its
// pending bit stays clear after reset.
module reg_scoreboard
    import banco_regs_pkg::*;
#(
    parameter int ADDR_W   = BANCO_ADDR_W,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              pend_a,
    output logic              pend_b,
    output logic [ADDR_W:0]   pend_cnt
);

    localparam int N_REGS = 2 ** ADDR_W;

    logic [N_REGS-1:0] pend_r;
    logic [N_REGS-1:0] pend_next_s;
    logic              wr_ok_s;
    logic              rsv_ok_s;
    logic [ADDR_W:0]   cnt_s;

    // Qualify strobes against the hard-wired zero register.
    always_comb begin
        wr_ok_s  = wr_en;
        rsv_ok_s = rsv_en;
        if ((ZERO_REG != 0) && (wr_addr == {ADDR_W{1'b0}})) begin
            wr_ok_s = 1'b0;
        end else begin
            wr_ok_s = wr_en;
        end
        if ((ZERO_REG != 0) && (rsv_addr == {ADDR_W{1'b0}})) begin
            rsv_ok_s = 1'b0;
        end else begin
            rsv_ok_s = rsv_en;
        end
    end

    // Next pending vector: clear on write first, then set on reserve, so a
    // same-address write+reserve leaves the bit set for the new producer.
    always_comb begin
        pend_next_s = pend_r;
        if (wr_ok_s) begin
            pend_next_s[wr_addr] = 1'b0;
        end else begin
            pend_next_s[wr_addr] = pend_r[wr_addr];
        end
        if (rsv_ok_s) begin
            pend_next_s[rsv_addr] = 1'b1;
        end else begin
            pend_next_s[rsv_addr] = pend_next_s[rsv_addr];
        end
    end

    // Pending-bit state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r <= {N_REGS{1'b0}};
        end else begin
            pend_r <= pend_next_s;
        end
    end

    // Popcount of pending bits; one spare bit so a full vector does not wrap.
    always_comb begin
        cnt_s = {(ADDR_W+1){1'b0}};
        for (int i = 0; i < N_REGS; i++) begin
            cnt_s = cnt_s + {{ADDR_W{1'b0}}, pend_r[i]};
        end
    end

    assign pend_a   = pend_r[rd_addr_a];
    assign pend_b   = pend_r[rd_addr_b];
    assign pend_cnt = cnt_s;

endmodule

// File: rtl/banco_regs_param.sv
// banco_regs_param: parametrised register file with two combinational read
// ports, one write port, synchronous clear and a RAW-hazard scoreboard.
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   rd_addr_a/b -> rd_data_a/b   combinational reads
//   busy_a/b                     register at the read address has a pending write
//   wr_en, wr_addr, wr_data      write port (posedge)
//   rsv_en, rsv_addr             mark a destination register pending
//   pend_cnt                     number of pending registers
// Optional feature macro: BANCO_BYPASS_EN enables write-through forwarding
// from the write port to matching read ports in the same cycle (not while
// rst is high, never for the zero register).
module banco_regs_param
    import banco_regs_pkg::*;
#(
    parameter int DATA_W   = BANCO_DATA_W,
    parameter int ADDR_W   = BANCO_ADDR_W,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              busy_a,
    output logic              busy_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [ADDR_W:0]   pend_cnt
);

    localparam int N_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_r [N_REGS];
    logic              wr_ok_s;
    logic              fwd_a_s;
    logic              fwd_b_s;
    logic              pend_a_s;
    logic              pend_b_s;

    reg_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .pend_a    (pend_a_s),
        .pend_b    (pend_b_s),
        .pend_cnt  (pend_cnt)
    );

    // Writes to the hard-wired zero register are dropped.
    always_comb begin
        wr_ok_s = wr_en;
        if ((ZERO_REG != 0) && (wr_addr == {ADDR_W{1'b0}})) begin
            wr_ok_s = 1'b0;
        end else begin
            wr_ok_s = wr_en;
        end
    end

    // Storage array: synchronous clear has priority over the write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REGS; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_ok_s) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Forwarding select per read port; wr_ok_s already excludes the zero register.
    always_comb begin
        fwd_a_s = 1'b0;
        fwd_b_s = 1'b0;
`ifdef BANCO_BYPASS_EN
        fwd_a_s = wr_ok_s && !rst && (wr_addr == rd_addr_a);
        fwd_b_s = wr_ok_s && !rst && (wr_addr == rd_addr_b);
`else
        fwd_a_s = 1'b0;
        fwd_b_s = 1'b0;
`endif
    end

    // Read port A: forwarded data, forced zero register, or stored contents.
    always_comb begin
        rd_data_a = mem_r[rd_addr_a];
        busy_a    = pend_a_s;
        if (fwd_a_s) begin
            rd_data_a = wr_data;
            busy_a    = 1'b0;
        end else if ((ZERO_REG != 0) && (rd_addr_a == {ADDR_W{1'b0}})) begin
            rd_data_a = {DATA_W{1'b0}};
            busy_a    = 1'b0;
        end else begin
            rd_data_a = mem_r[rd_addr_a];
            busy_a    = pend_a_s;
        end
    end

    // Read port B: same selection as port A.
    always_comb begin
        rd_data_b = mem_r[rd_addr_b];
        busy_b    = pend_b_s;
        if (fwd_b_s) begin
            rd_data_b = wr_data;
            busy_b    = 1'b0;
        end else if ((ZERO_REG != 0) && (rd_addr_b == {ADDR_W{1'b0}})) begin
            rd_data_b = {DATA_W{1'b0}};
            busy_b    = 1'b0;
        end else begin
            rd_data_b = mem_r[rd_addr_b];
            busy_b    = pend_b_s;
        end
    end

endmodule

// File: tb/tb_banco_regs_param.sv
// Self-checking bench for banco_regs_param. Two instances share all inputs:
// inst 0 with ZERO_REG=0 and inst 1 with ZERO_REG=1. Expectations come from a
// small behavioural model of the register file and flow through a queue.
module tb_banco_regs_param;
    import banco_regs_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    reg_addr_t  rd_addr_a, rd_addr_b, wr_addr, rsv_addr;
    reg_data_t  wr_data;
    logic       wr_en, rsv_en;

    reg_data_t  rda [2];
    reg_data_t  rdb [2];
    logic       bsa [2];
    logic       bsb [2];
    logic [4:0] pcnt [2];

    banco_regs_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0)) dut0 (
        .clk(clk), .rst(rst), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rda[0]), .rd_data_b(rdb[0]), .busy_a(bsa[0]), .busy_b(bsb[0]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pend_cnt(pcnt[0]));

    banco_regs_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1)) dut1 (
        .clk(clk), .rst(rst), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rda[1]), .rd_data_b(rdb[1]), .busy_a(bsa[1]), .busy_b(bsb[1]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pend_cnt(pcnt[1]));

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          inst;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] mem_m  [2][16];
    logic [15:0] pend_m [2];

    function automatic bit zero_hit(int inst, logic [3:0] a);
        return (inst == 1) && (a == 4'd0);
    endfunction

    function automatic bit fwd(int inst, logic [3:0] a);
`ifdef BANCO_BYPASS_EN
        return !rst && wr_en && (wr_addr == a) && !zero_hit(inst, a);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] exp_data(int inst, logic [3:0] a);
        if (fwd(inst, a)) return {16'd0, wr_data};
        if (zero_hit(inst, a)) return 32'd0;
        return {16'd0, mem_m[inst][a]};
    endfunction

    function automatic logic [31:0] exp_busy(int inst, logic [3:0] a);
        if (fwd(inst, a) || zero_hit(inst, a)) return 32'd0;
        return {31'd0, pend_m[inst][a]};
    endfunction

    function automatic logic [31:0] exp_cnt(int inst);
        logic [31:0] c = 32'd0;
        for (int i = 0; i < 16; i++) c = c + {31'd0, pend_m[inst][i]};
        return c;
    endfunction

    function automatic logic [31:0] observe(int inst, int sel);
        case (sel)
            0:       return {16'd0, rda[inst]};
            1:       return {16'd0, rdb[inst]};
            2:       return {31'd0, bsa[inst]};
            3:       return {31'd0, bsb[inst]};
            default: return {27'd0, pcnt[inst]};
        endcase
    endfunction

    task automatic push_exp(input string tag);
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back('{tag, k, 0, exp_data(k, rd_addr_a)});
            exp_q.push_back('{tag, k, 1, exp_data(k, rd_addr_b)});
            exp_q.push_back('{tag, k, 2, exp_busy(k, rd_addr_a)});
            exp_q.push_back('{tag, k, 3, exp_busy(k, rd_addr_b)});
            exp_q.push_back('{tag, k, 4, exp_cnt(k)});
        end
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            obs = observe(e.inst, e.sel);
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s inst%0d sel%0d: observed %h expected %h",
                       e.tag, e.inst, e.sel, obs, e.exp);
            end
        end
    endtask

    task automatic apply_model();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                pend_m[k] = 16'd0;
                for (int i = 0; i < 16; i++) mem_m[k][i] = 16'd0;
            end else begin
                if (wr_en && !zero_hit(k, wr_addr)) begin
                    mem_m[k][wr_addr]  = wr_data;
                    pend_m[k][wr_addr] = 1'b0;
                end
                if (rsv_en && !zero_hit(k, rsv_addr)) pend_m[k][rsv_addr] = 1'b1;
            end
        end
    endtask

    // One clock: drive, optional same-cycle check, edge, strobes dropped, check.
    task automatic cycle(input logic r, input logic we, input logic [3:0] wa,
                         input logic [15:0] wd, input logic re, input logic [3:0] rva,
                         input logic [3:0] a, input logic [3:0] b,
                         input string tag, input bit pre);
        @(negedge clk);
        rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
        rsv_en = re; rsv_addr = rva; rd_addr_a = a; rd_addr_b = b;
        if (pre) begin
            #1;
            push_exp({tag, "_pre"});
            drain();
        end
        apply_model();
        @(posedge clk);
        #1;
        rst = 1'b0; wr_en = 1'b0; rsv_en = 1'b0;
        #1;
        push_exp(tag);
        drain();
    endtask

    task automatic look(input logic [3:0] a, input logic [3:0] b, input string tag);
        rd_addr_a = a; rd_addr_b = b;
        #1;
        push_exp(tag);
        drain();
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; rsv_en = 1'b0; wr_addr = 4'd0; wr_data = 16'd0;
        rsv_addr = 4'd0; rd_addr_a = 4'd0; rd_addr_b = 4'd0;
        pend_m[0] = 16'd0; pend_m[1] = 16'd0;

        // Reset and sweep every register.
        cycle(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0, 4'd15, "reset", 1'b0);
        for (int i = 0; i < 8; i++) look(4'(i), 4'(15 - i), "reset_sweep");

        // 1: write r5, read on both ports.
        cycle(1'b0, 1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd0, 4'd5, 4'd5, "t1_wr_r5", 1'b0);
        look(4'd4, 4'd6, "t1_neighbours");

        // 2: reserve r3, then write it.
        cycle(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 4'd3, 4'd5, "t2_rsv_r3", 1'b0);
        cycle(1'b0, 1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 4'd3, 4'd3, "t2_wr_r3", 1'b1);

        // 3: write and reserve r7 in the same cycle.
        cycle(1'b0, 1'b1, 4'd7, 16'hAAAA, 1'b1, 4'd7, 4'd7, 4'd7, "t3_wr_rsv_r7", 1'b0);

        // Different addresses, double reserve, write to non-pending register.
        cycle(1'b0, 1'b1, 4'd8, 16'h0808, 1'b1, 4'd10, 4'd8, 4'd10, "diff_addr", 1'b0);
        cycle(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd10, 4'd10, 4'd7, "double_rsv", 1'b0);
        cycle(1'b0, 1'b1, 4'd11, 16'hC0DE, 1'b0, 4'd0, 4'd11, 4'd10, "wr_not_pend", 1'b0);

        // 5: register 0 write and reserve (dropped only on the ZERO_REG instance).
        cycle(1'b0, 1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd0, 4'd0, 4'd0, "t5_r0", 1'b1);

        // 6: write to pending r9 while it is being read.
        cycle(1'b0, 1'b1, 4'd9, 16'h1111, 1'b0, 4'd0, 4'd9, 4'd8, "t6_init", 1'b0);
        cycle(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd9, 4'd9, 4'd8, "t6_rsv", 1'b0);
        cycle(1'b0, 1'b1, 4'd9, 16'h5A5A, 1'b0, 4'd0, 4'd9, 4'd3, "t6_wr", 1'b1);

        // Reserve every register: pend_cnt reaches its maximum without wrapping.
        for (int i = 0; i < 16; i++)
            cycle(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'(i), 4'(i), 4'd0, "fill", 1'b0);

        // 4: reserve r1, r2, r4 then reset together with a write to r2.
        cycle(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd1, 4'd1, 4'd2, "t4_rsv1", 1'b0);
        cycle(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd2, 4'd1, 4'd2, "t4_rsv2", 1'b0);
        cycle(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd4, 4'd4, 4'd2, "t4_rsv4", 1'b0);
        cycle(1'b1, 1'b1, 4'd2, 16'h2222, 1'b1, 4'd6, 4'd2, 4'd5, "t4_rst", 1'b1);
        for (int i = 0; i < 8; i++) look(4'(i), 4'(15 - i), "t4_sweep");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
